// File: rtl/mem_interface.sv
// MAR/MDR register pair in front of a 512x32 RAM, sequenced by a level-request
// read/write FSM. Define MEM_WAIT_STATES_EN to stretch ACCESS to three cycles.
module mem_interface (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] BusMuxOut,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] MDR_q,
    output logic [8:0]  MAR_q,
    output logic        Busy,
    output logic        Done,
    output logic        AccessErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        XFER   = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        op_write_q, op_write_d;
    logic [8:0]  mar_d;
    logic [31:0] mdr_d;
    logic        busy_d, done_d, err_d;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // RAM contents survive Reset, so the array has no reset branch.
    logic [31:0] mem [0:511];

`ifdef MEM_WAIT_STATES_EN
    logic [1:0]  wait_q, wait_d;
`endif

    assign mem_rdata = mem[MAR_q];

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        mar_d      = MAR_q;
        mdr_d      = MDR_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
`ifdef MEM_WAIT_STATES_EN
        wait_d     = wait_q;
`endif
        case (state_q)
            IDLE: begin
                // Loads land on the same edge as a request, so the access sees them.
                if (MARin) mar_d = BusMuxOut[8:0];
                if (MDRin) mdr_d = BusMuxOut;
                if (Read || Write) begin
                    state_d    = ACCESS;
                    op_write_d = Write && !Read;
                    err_d      = Read && Write;
`ifdef MEM_WAIT_STATES_EN
                    wait_d     = 2'd2;
`endif
                end
            end
            ACCESS: begin
`ifdef MEM_WAIT_STATES_EN
                if (wait_q == 2'd0) state_d = XFER;
                else                wait_d  = wait_q - 2'd1;
`else
                state_d = XFER;
`endif
            end
            XFER: begin
                state_d = HOLD;
                done_d  = 1'b1;
                if (op_write_q) mem_we = 1'b1;
                else            mdr_d  = mem_rdata;
            end
            HOLD: begin
                // Wait for both request levels to drop so a held level cannot retrigger.
                if (!Read && !Write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            MAR_q      <= 9'd0;
            MDR_q      <= 32'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            AccessErr  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            MAR_q      <= mar_d;
            MDR_q      <= mdr_d;
            Busy       <= busy_d;
            Done       <= done_d;
            AccessErr  <= err_d;
        end
    end

`ifdef MEM_WAIT_STATES_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) wait_q <= 2'd0;
        else       wait_q <= wait_d;
    end
`endif

    always_ff @(posedge Clock) begin
        if (mem_we) mem[MAR_q] <= MDR_q;
    end

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: reference model of MAR/MDR/RAM,
// expected-value queue filled by the driver and drained by a Done monitor.
module tb_mem_interface;

`ifdef MEM_WAIT_STATES_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] BusMuxOut = 32'd0;
    logic        MARin = 1'b0;
    logic        MDRin = 1'b0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] MDR_q;
    logic [8:0]  MAR_q;
    logic        Busy;
    logic        Done;
    logic        AccessErr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    logic [31:0] m_mem [0:511];
    logic [8:0]  m_mar = 9'd0;
    logic [31:0] m_mdr = 32'd0;

    mem_interface dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .MDR_q     (MDR_q),
        .MAR_q     (MAR_q),
        .Busy      (Busy),
        .Done      (Done),
        .AccessErr (AccessErr)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding access.
    always @(negedge Clock) begin
        if (!Reset && Done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                check("mdr_at_done", MDR_q, exp_q.pop_front());
                check("done_latency", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input bit lm, input bit ld, input logic [31:0] bus);
        @(negedge Clock);
        BusMuxOut = bus;
        MARin = lm;
        MDRin = ld;
        if (lm) m_mar = bus[8:0];
        if (ld) m_mdr = bus;
        @(negedge Clock);
        MARin = 1'b0;
        MDRin = 1'b0;
        check("mar_load", {23'd0, MAR_q}, {23'd0, m_mar});
        check("mdr_load", MDR_q, m_mdr);
    endtask

    // Junk loads while busy; mode 1 random, mode 2 all-ones into MDR.
    task automatic drive_noise(input int mode);
        if (mode == 1) begin
            BusMuxOut = $urandom;
            MARin = 1'($urandom_range(0, 1));
            MDRin = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
            BusMuxOut = 32'hFFFF_FFFF;
            MARin = 1'b0;
            MDRin = 1'b1;
        end else begin
            MARin = 1'b0;
            MDRin = 1'b0;
        end
    endtask

    task automatic do_access(input bit rd, input bit wr, input bit lm, input bit ld,
                             input logic [31:0] bus, input int extra, input int noise);
        int dones;
        int waited;
        @(negedge Clock);
        BusMuxOut = bus;
        MARin = lm;
        MDRin = ld;
        Read  = rd;
        Write = wr;
        if (lm) m_mar = bus[8:0];
        if (ld) m_mdr = bus;
        if (rd) m_mdr = m_mem[m_mar];
        else    m_mem[m_mar] = m_mdr;
        exp_q.push_back(m_mdr);
        exp_cyc_q.push_back(cyc + 1 + LAT);
        @(negedge Clock);
        check("access_err", {31'd0, AccessErr}, {31'd0, rd && wr});
        check("busy_start", {31'd0, Busy}, 32'd1);
        dones = 0;
        waited = 0;
        while (dones == 0 && waited < 20) begin
            drive_noise(noise);
            @(negedge Clock);
            waited++;
            if (waited == 1) check("err_pulse_end", {31'd0, AccessErr}, 32'd0);
            if (Done) dones++;
        end
        if (dones == 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        for (int i = 0; i < extra; i++) begin
            drive_noise(noise);
            @(negedge Clock);
            if (Done) dones++;
            check("busy_hold", {31'd0, Busy}, 32'd1);
        end
        Read = 1'b0;
        Write = 1'b0;
        MARin = 1'b0;
        MDRin = 1'b0;
        @(negedge Clock);
        if (Done) dones++;
        check("busy_release", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        if (Done) dones++;
        check("done_count", dones, 32'd1);
        check("mar_after", {23'd0, MAR_q}, {23'd0, m_mar});
        check("mdr_after", MDR_q, m_mdr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mdr"}, MDR_q, 32'd0);
        check({tag, "_mar"}, {23'd0, MAR_q}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_done"}, {31'd0, Done}, 32'd0);
        check({tag, "_err"}, {31'd0, AccessErr}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rd, wr, lm, ld;
        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;

        // Directed register loads; upper address bits are dropped.
        load(1'b1, 1'b0, 32'h0000_0203);
        check("mar_0203", {23'd0, MAR_q}, 32'h0000_0003);
        load(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("mdr_deadbeef", MDR_q, 32'hDEAD_BEEF);

        // Fill the whole RAM so every later read has a known answer.
        for (int a = 0; a < 512; a++) begin
            load(1'b1, 1'b0, ($urandom & 32'hFFFF_FE00) | 32'(a));
            do_access(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Write then read back at address 5.
        load(1'b1, 1'b0, 32'h0000_0005);
        load(1'b0, 1'b1, 32'h1234_5678);
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
        load(1'b0, 1'b1, 32'h0000_0000);
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        check("readback_5", MDR_q, 32'h1234_5678);

        // Read and Write together: treated as a read, RAM untouched.
        load(1'b0, 1'b1, 32'hAAAA_5555);
        do_access(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1, 0);
        check("both_reads", MDR_q, 32'h1234_5678);
        load(1'b0, 1'b1, 32'h0000_0000);
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        check("both_ram_kept", MDR_q, 32'h1234_5678);

        // Long held Read with MDRin hammered while busy.
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8, 2);
        check("hold_mdr", MDR_q, 32'h1234_5678);

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            lm = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                load(lm, ld, $urandom);
            do_access(rd, wr, lm, ld, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset during ACCESS of a write to address 7.
        load(1'b1, 1'b0, 32'h0000_0007);
        load(1'b0, 1'b1, 32'h0BAD_F00D);
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
        load(1'b0, 1'b1, 32'h7777_7777);
        @(negedge Clock);
        Write = 1'b1;
        @(negedge Clock);
        check("busy_pre_reset", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        check_all_zero("midreset");
        Write = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        m_mar = 9'd0;
        m_mdr = 32'd0;
        @(negedge Clock);
        Reset = 1'b0;
        load(1'b1, 1'b0, 32'h0000_0007);
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        check("aborted_write", MDR_q, 32'h0BAD_F00D);

        repeat (3) @(negedge Clock);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have port Clock, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port BusMuxOut, input, 32, datapath bus value.
REQ-004 SHALL have port MARin, input, 1, load MAR from BusMuxOut[8:0].
REQ-005 SHALL have port MDRin, input, 1, load MDR from BusMuxOut.
REQ-006 SHALL have port Read, input, 1, level request for a memory read into MDR.
REQ-007 SHALL have port Write, input, 1, level request for a memory write of MDR.
REQ-008 SHALL have port MDR_q, output, 32, MDR contents, reset 0.
REQ-009 SHALL have port MAR_q, output, 9, MAR contents, reset 0.
REQ-010 SHALL have port Busy, output, 1, high whenever the FSM is not IDLE, reset 0.
REQ-011 SHALL have port Done, output, 1, one-cycle pulse marking transfer completion, reset 0.
REQ-012 SHALL have port AccessErr, output, 1, one-cycle pulse on simultaneous Read and Write, reset 0.

Function
REQ-013 SHALL contain a 512 x 32 RAM addressed by MAR_q.
REQ-014 SHALL use FSM states IDLE, ACCESS, XFER and HOLD.
REQ-015 In IDLE, MARin SHALL load MAR; MDRin SHALL load MDR from BusMuxOut; both in the same cycle SHALL load both.
REQ-016 Outside IDLE, MARin and MDRin SHALL be ignored and MAR and MDR SHALL hold.
REQ-017 IDLE with Read=1 or Write=1 sampled SHALL go to ACCESS and latch the operation type; otherwise IDLE SHALL hold.
REQ-018 Read=1 and Write=1 sampled together in IDLE SHALL perform a read, and AccessErr SHALL pulse high for the following cycle.
REQ-019 Requests and MARin/MDRin sampled in IDLE on the same edge SHALL apply the loads first, so the access uses the new MAR/MDR.
REQ-020 ACCESS SHALL last 1 cycle, extended per REQ-030, then go to XFER.
REQ-021 XFER SHALL last 1 cycle and then go to HOLD.
REQ-022 On the edge leaving XFER, a read SHALL load MDR from RAM[MAR]; a write SHALL store MDR into RAM[MAR].
REQ-023 Done SHALL be high for exactly the one cycle following that transfer edge.
REQ-024 HOLD SHALL remain until Read=0 and Write=0 are sampled, then go to IDLE; this handshake prevents retrigger on a held level.
REQ-025 Busy SHALL be registered from the state: high in ACCESS, XFER and HOLD.
REQ-026 RAM SHALL be written only as specified in REQ-022.
REQ-027 Addresses SHALL use BusMuxOut[8:0] only; upper bits SHALL be ignored; no wrap or range error is possible.

Reset
REQ-028 Reset SHALL force IDLE and clear MAR_q, MDR_q, Done, Busy and AccessErr immediately, in any state.
REQ-029 Reset SHALL NOT clear RAM contents; a write interrupted before its XFER edge SHALL leave RAM unchanged.

Configuration
REQ-030 With MEM_WAIT_STATES_EN defined, ACCESS SHALL last 3 cycles (2-bit down-counter, reloaded on IDLE->ACCESS), giving Done 4 edges after request sampling.
REQ-031 Without MEM_WAIT_STATES_EN, ACCESS SHALL last 1 cycle, giving Done 2 edges after request sampling, and no wait counter SHALL exist.

Verification
REQ-032 SHALL verify: MARin with bus=0x0000_0203 -> MAR_q=0x003; MDRin with bus=0xDEAD_BEEF -> MDR_q=0xDEADBEEF.
REQ-033 SHALL verify: write MDR=0x1234_5678 to MAR=5, then read MAR=5 -> MDR_q=0x12345678; Done pulses once per access at 2 edges (macro off) or 4 edges (macro on) after the request.
REQ-034 SHALL verify: Read and Write both high in IDLE -> AccessErr pulses 1 cycle, RAM unchanged, MDR_q=RAM[MAR].
REQ-035 SHALL verify: Read held high for 10 cycles -> exactly one Done, Busy stays high until Read drops, then returns to IDLE.
REQ-036 SHALL verify: MDRin with bus=0xFFFF_FFFF while Busy=1 -> MDR_q unchanged; Reset during ACCESS of a write to addr 7 -> RAM[7] unchanged, all outputs 0.
